// File: rtl/cpu_mem_arbiter_pkg.sv
// Shared types and helpers for the CPU/BRAM arbiter.
//   arb_state_t : controller state code, with ST_* constants
//   arb_op_t    : kind of access currently in flight
//   byte_ofs()  : number of byte-offset bits in an XLEN-wide word address
package cpu_mem_arbiter_pkg;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ST_IDLE  = 2'd0;
  localparam arb_state_t ST_RD    = 2'd1;
  localparam arb_state_t ST_WR    = 2'd2;
  localparam arb_state_t ST_FENCE = 2'd3;

  typedef enum logic [1:0] {
    OP_IF = 2'd0,
    OP_LD = 2'd1,
    OP_ST = 2'd2
  } arb_op_t;

  localparam int XLEN_DEF = 64;
  localparam int BYTE_OFS = $clog2(XLEN_DEF / 8);

  function automatic int byte_ofs(input int xlen);
    return $clog2(xlen / 8);
  endfunction

endpackage

// File: rtl/cpu_mem_arbiter.sv
// Shares one single-port BRAM between the instruction-fetch port and the
// data load/store port of the core. One access at a time is sequenced by a
// registered FSM; every output is a flop.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | waiting; the only state in which requests are sampled
// RD       | read issued (fetch or load); cnt counts down the BRAM latency,
//          | pulse issued at cnt==1, cnt==0 is the pulse cycle itself
// WR       | store pulse cycle (ram_en/ram_we driven, d_ready high)
// FENCE    | fence_done pulse cycle
//
// Ports:
//   clk, rst                   clock, async active-high reset
//   if_req/if_addr             fetch request (held until if_valid)
//   if_rdata/if_valid          fetched instruction word and done pulse
//   d_re/d_we/d_addr/d_wdata/d_be  data request (held until d_ready)
//   d_rdata/d_ready            load data and done pulse
//   fence_req/fence_done       fence handshake
//   bus_err                    pulses with the done pulse of a faulting access
//   ram_en/ram_we/ram_addr/ram_wdata/ram_rdata  BRAM port
module cpu_mem_arbiter
  import cpu_mem_arbiter_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int ADDR_W  = 14,
  parameter int RAM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [XLEN-1:0]   if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_valid,
  input  logic              d_re,
  input  logic              d_we,
  input  logic [XLEN-1:0]   d_addr,
  input  logic [XLEN-1:0]   d_wdata,
  input  logic [XLEN/8-1:0] d_be,
  output logic [XLEN-1:0]   d_rdata,
  output logic              d_ready,
  input  logic              fence_req,
  output logic              fence_done,
  output logic              bus_err,
  output logic              ram_en,
  output logic [XLEN/8-1:0] ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [XLEN-1:0]   ram_wdata,
  input  logic [XLEN-1:0]   ram_rdata
);

  localparam int OFS   = byte_ofs(XLEN);
  localparam int TOP   = ADDR_W + OFS;  // lowest byte-address bit outside the RAM
  localparam int CNT_W = $clog2(RAM_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RAM_LAT);

  arb_state_t        state;
  arb_op_t           op;
  logic [CNT_W-1:0]  cnt;
  logic              lane_hi;

  logic              d_oor;
  logic              if_bad;
  logic [ADDR_W-1:0] d_word;
  logic [ADDR_W-1:0] if_word;

  assign d_oor   = |(d_addr >> TOP);
  assign if_bad  = (|(if_addr >> TOP)) | (|if_addr[1:0]);
  assign d_word  = d_addr[TOP-1:OFS];
  assign if_word = if_addr[TOP-1:OFS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      op         <= OP_IF;
      cnt        <= '0;
      lane_hi    <= 1'b0;
      if_rdata   <= '0;
      if_valid   <= 1'b0;
      d_rdata    <= '0;
      d_ready    <= 1'b0;
      fence_done <= 1'b0;
      bus_err    <= 1'b0;
      ram_en     <= 1'b0;
      ram_we     <= '0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
    end else begin
      if_valid   <= 1'b0;
      d_ready    <= 1'b0;
      fence_done <= 1'b0;
      bus_err    <= 1'b0;
      ram_en     <= 1'b0;
      ram_we     <= '0;
      case (state)
        ST_IDLE: begin
          if (d_we) begin
            // A simultaneous d_re is a core bug: still do the store, flag it.
            op      <= OP_ST;
            state   <= ST_WR;
            d_ready <= 1'b1;
            bus_err <= d_re | d_oor;
            if (!d_oor) begin
              ram_en    <= 1'b1;
              ram_we    <= d_be;
              ram_addr  <= d_word;
              ram_wdata <= d_wdata;
            end
          end else if (d_re) begin
            op    <= OP_LD;
            state <= ST_RD;
            if (d_oor) begin
              // Skip the RAM; cnt==0 makes RD the pulse cycle directly.
              cnt     <= '0;
              d_ready <= 1'b1;
              bus_err <= 1'b1;
              d_rdata <= '0;
            end else begin
              cnt      <= CNT_LOAD;
              ram_en   <= 1'b1;
              ram_addr <= d_word;
            end
          end else if (fence_req) begin
            // Only one access is ever in flight, so IDLE means drained.
            state      <= ST_FENCE;
            fence_done <= 1'b1;
          end else if (if_req) begin
            op      <= OP_IF;
            state   <= ST_RD;
            lane_hi <= if_addr[2];
            if (if_bad) begin
              cnt      <= '0;
              if_valid <= 1'b1;
              bus_err  <= 1'b1;
              if_rdata <= '0;
            end else begin
              cnt      <= CNT_LOAD;
              ram_en   <= 1'b1;
              ram_addr <= if_word;
            end
          end
        end
        ST_RD: begin
          if (cnt == CNT_ONE) begin
            cnt <= '0;
            if (op == OP_IF) begin
              if_valid <= 1'b1;
              if_rdata <= lane_hi ? ram_rdata[63:32] : ram_rdata[31:0];
            end else begin
              d_ready <= 1'b1;
              d_rdata <= ram_rdata;
            end
          end else if (cnt == '0) begin
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
